frame_unpacker: RTL and testbench
=================================

Name: frame_unpacker

Overview:
- Receive side of the packed state/data frame: accepts 64-bit MyStruct_t frames, validates them and recovers the original 8-bit payload.
- Tracks the FOO/BAR alternation carried in the state field and keeps saturating error counters.
- Sits downstream of the frame packer. Its output feeds byte-wide consumers through a one-entry registered valid/ready stage.

Parameters:
- CNT_W, 8, width of each saturating counter.
- MAGIC, 16'hABCD, expected token in data[15:0].

Ports:
- clock  in  1  system clock
- clear_n  in  1  asynchronous active-low reset
- in_valid  in  1  frame present
- in_ready  out  1  frame accepted when in_valid && in_ready
- in_frame  in  64  MyStruct_t {state[63:32], data[31:0]}
- out_valid  out  1  recovered byte available
- out_ready  in  1  consumer accepts byte
- out_data  out  8  recovered payload
- out_state  out  1  state tag of the frame (0=FOO, 1=BAR)
- locked  out  1  sequence tracker is in LOCKED
- fmt_err_cnt  out  CNT_W  count of malformed frames, saturating
- seq_err_cnt  out  CNT_W  count of sequence breaks, saturating

Behaviour:
- Reset (clear_n low, asynchronous): out_valid=0, out_data=0, out_state=0, locked=0, both counters 0, FSM=SYNC, expected state=FOO.
- Handshake:
  - in_ready = !out_valid || out_ready (combinational; no input-side buffering).
  - Output holds stable while out_valid && !out_ready.
- Frame check on accept:
  - Well-formed iff state field is 0 or 1 (upper 31 bits zero), data[31:24] == ~data[23:16], and data[15:0] == MAGIC.
  - Malformed frame: consumed but not forwarded. fmt_err_cnt increments. FSM and expected state are unchanged.
- FSM, SYNC:
  - First well-formed frame is forwarded.
  - Expected state becomes swap(frame state).
  - Transition to LOCKED.
- FSM, LOCKED:
  - Well-formed frame whose state equals expected: forwarded; expected toggles.
  - Well-formed frame whose state does not equal expected: forwarded; seq_err_cnt increments; FSM returns to SYNC.
  - That same frame seeds nothing. Resync occurs on the next well-formed frame.
- Forwarding: out_data = data[23:16] and out_state = state[0], registered on the accept edge.
  - Latency is exactly 1 cycle: out_valid rises the cycle after the accept.
- Simultaneous pop and accept (out_valid && out_ready && in_valid): the new byte is loaded in the same cycle, so out_valid stays 1 with no bubble.
- A malformed frame accepted while the old byte pops leaves out_valid=0 next cycle.
- Counters saturate at all-ones. Reaching that value does not wrap and does not block traffic.
- locked = (FSM == LOCKED), registered.
- Reset asserted mid-stream discards the pending output byte immediately.

Optional Feature:
- Macro: FRAME_UNPACKER_STRICT_EN.
- Defined:
  - Frames with a sequence error are dropped, not forwarded.
  - While in SYNC, frames are only forwarded once two consecutive well-formed frames alternate correctly. The first frame seeds the expected state; the second is checked, forwarded, and moves the FSM to LOCKED.
- Undefined: behaviour as above. The sequence check only counts errors and forces resync; every well-formed frame is forwarded.

Decomposition:
- Shared package frame_pkg holds:
  - State_t enum {FOO, BAR}
  - MyStruct_t packed struct
  - MAGIC_TOKEN constant
  - swap_state function, shared with the packer
- Packer and unpacker both import frame_pkg.
- One sub-module, sat_counter (width CNT_W, inc input, saturating), instantiated twice.
- FSM and frame check stay in frame_unpacker.

Test Plan:
- Reset, then frames {state=0,data=32'hA55AABCD} and {1,32'h5AA5ABCD} with out_ready=1. Expected: out_data 5A then A5, out_state 0 then 1, one-cycle latency, locked=1 after the first frame.
- Frame with data=32'hA55A1234. Expected: no output, fmt_err_cnt=1, locked unchanged.
- Frame with data=32'hA45AABCD (complement fails). Expected: dropped, fmt_err_cnt increments.
- Frame with state=32'd2. Expected: dropped, fmt_err_cnt increments.
- In LOCKED expecting BAR, send state=0 (data 32'hFF00ABCD). Expected: out_data 00 forwarded (dropped under FRAME_UNPACKER_STRICT_EN), seq_err_cnt=1, locked=0.
- Hold out_ready=0 for 5 cycles with in_valid=1. Expected: in_ready=0 and out_data stable. Then out_ready=1 with back-to-back valid frames gives one byte per cycle.
- 300 malformed frames. Expected: fmt_err_cnt sticks at 8'hFF and forwarding still works.
- Pulse clear_n low while out_valid=1, mid-cycle. Expected: out_valid and counters clear immediately, FSM=SYNC.

Source files
------------

// File: rtl/frame_pkg.sv
// Shared frame definitions for the state/data frame packer and unpacker.
package frame_pkg;

    typedef enum logic {
        FOO = 1'b0,
        BAR = 1'b1
    } State_t;

    typedef struct packed {
        logic [31:0] state;
        logic [31:0] data;
    } MyStruct_t;

    localparam logic [15:0] MAGIC_TOKEN = 16'hABCD;

    typedef enum logic {
        SYNC   = 1'b0,
        LOCKED = 1'b1
    } sync_state_t;

    function automatic State_t swap_state(input State_t s);
        return (s == FOO) ? BAR : FOO;
    endfunction

endpackage

// File: rtl/frame_unpacker_sat_counter.sv
// Saturating up-counter: sticks at all-ones instead of wrapping.
module sat_counter #(
    parameter int W = 8
) (
    input  logic         clock,
    input  logic         clear_n,
    input  logic         inc,
    output logic [W-1:0] count
);

    logic [W-1:0] count_q;
    logic [W-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (inc && (count_q != {W{1'b1}})) begin
            count_d = count_q + W'(1);
        end
    end

    always_ff @(posedge clock or negedge clear_n) begin
        if (!clear_n) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count = count_q;

endmodule

// File: rtl/frame_unpacker.sv
// Frame unpacker: validates MyStruct_t frames, tracks FOO/BAR alternation, forwards the payload byte.
// Optional FRAME_UNPACKER_STRICT_EN: drop sequence-error frames and require a seeded pair before locking.
module frame_unpacker
    import frame_pkg::*;
#(
    parameter int          CNT_W = 8,
    parameter logic [15:0] MAGIC = MAGIC_TOKEN
) (
    input  logic             clock,
    input  logic             clear_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [63:0]      in_frame,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [7:0]       out_data,
    output logic             out_state,
    output logic             locked,
    output logic [CNT_W-1:0] fmt_err_cnt,
    output logic [CNT_W-1:0] seq_err_cnt
);

    MyStruct_t   frame;
    State_t      frame_state;
    logic        well_formed;
    logic        accept;

    sync_state_t fsm_q,       fsm_d;
    State_t      exp_q,       exp_d;
    logic        out_valid_q, out_valid_d;
    logic [7:0]  out_data_q,  out_data_d;
    State_t      out_state_q, out_state_d;
    logic        locked_q,    locked_d;
`ifdef FRAME_UNPACKER_STRICT_EN
    logic        seeded_q,    seeded_d;
`endif

    logic        fwd;
    logic        fmt_inc;
    logic        seq_inc;

    assign frame       = in_frame;
    assign frame_state = State_t'(frame.state[0]);
    assign well_formed = (frame.state[31:1] == 31'd0)
                      && (frame.data[31:24] == ~frame.data[23:16])
                      && (frame.data[15:0] == MAGIC);

    // No input buffering: a frame is only taken when the output slot is free or draining.
    assign in_ready = !out_valid_q || out_ready;
    assign accept   = in_valid && in_ready;

    always_comb begin
        fsm_d    = fsm_q;
        exp_d    = exp_q;
        fwd      = 1'b0;
        fmt_inc  = 1'b0;
        seq_inc  = 1'b0;
`ifdef FRAME_UNPACKER_STRICT_EN
        seeded_d = seeded_q;
`endif
        if (accept) begin
            if (!well_formed) begin
                fmt_inc = 1'b1;
            end else begin
                case (fsm_q)
                    SYNC: begin
`ifdef FRAME_UNPACKER_STRICT_EN
                        // The first frame only seeds; a mismatching second frame reseeds.
                        if (!seeded_q) begin
                            seeded_d = 1'b1;
                            exp_d    = swap_state(frame_state);
                        end else if (frame_state == exp_q) begin
                            fwd      = 1'b1;
                            exp_d    = swap_state(exp_q);
                            fsm_d    = LOCKED;
                            seeded_d = 1'b0;
                        end else begin
                            exp_d    = swap_state(frame_state);
                        end
`else
                        fwd   = 1'b1;
                        exp_d = swap_state(frame_state);
                        fsm_d = LOCKED;
`endif
                    end
                    LOCKED: begin
                        if (frame_state == exp_q) begin
                            fwd   = 1'b1;
                            exp_d = swap_state(exp_q);
                        end else begin
`ifndef FRAME_UNPACKER_STRICT_EN
                            fwd   = 1'b1;
`endif
                            seq_inc = 1'b1;
                            fsm_d   = SYNC;
                        end
                    end
                    default: begin
                        fsm_d = SYNC;
                    end
                endcase
            end
        end
    end

    // A pop frees the slot; an accept in the same cycle refills it with no bubble.
    always_comb begin
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        out_state_d = out_state_q;
        if (out_valid_q && out_ready) begin
            out_valid_d = 1'b0;
        end
        if (accept) begin
            out_valid_d = fwd;
            if (fwd) begin
                out_data_d  = frame.data[23:16];
                out_state_d = frame_state;
            end
        end
        locked_d = (fsm_d == LOCKED);
    end

    always_ff @(posedge clock or negedge clear_n) begin
        if (!clear_n) begin
            fsm_q       <= SYNC;
            exp_q       <= FOO;
            out_valid_q <= 1'b0;
            out_data_q  <= 8'h00;
            out_state_q <= FOO;
            locked_q    <= 1'b0;
`ifdef FRAME_UNPACKER_STRICT_EN
            seeded_q    <= 1'b0;
`endif
        end else begin
            fsm_q       <= fsm_d;
            exp_q       <= exp_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_state_q <= out_state_d;
            locked_q    <= locked_d;
`ifdef FRAME_UNPACKER_STRICT_EN
            seeded_q    <= seeded_d;
`endif
        end
    end

    sat_counter #(.W(CNT_W)) u_fmt_cnt (
        .clock   (clock),
        .clear_n (clear_n),
        .inc     (fmt_inc),
        .count   (fmt_err_cnt)
    );

    sat_counter #(.W(CNT_W)) u_seq_cnt (
        .clock   (clock),
        .clear_n (clear_n),
        .inc     (seq_inc),
        .count   (seq_err_cnt)
    );

    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_state = out_state_q;
    assign locked    = locked_q;

endmodule

// File: tb/tb_frame_unpacker.sv
// Self-checking bench for frame_unpacker: reference model plus scoreboard of forwarded bytes.
module tb_frame_unpacker;

`ifdef FRAME_UNPACKER_STRICT_EN
    localparam bit STRICT = 1'b1;
`else
    localparam bit STRICT = 1'b0;
`endif

    logic        clock     = 1'b0;
    logic        clear_n   = 1'b0;
    logic        in_valid  = 1'b0;
    logic [63:0] in_frame  = 64'd0;
    logic        out_ready = 1'b0;
    logic        in_ready;
    logic        out_valid;
    logic [7:0]  out_data;
    logic        out_state;
    logic        locked;
    logic [7:0]  fmt_err_cnt;
    logic [7:0]  seq_err_cnt;

    int compared   = 0;
    int mismatched = 0;

    logic [8:0] sb_q[$];

    bit m_locked;
    bit m_exp;
    bit m_seeded;
    bit m_last_fwd;
    int m_fmt;
    int m_seq;

    frame_unpacker #(.CNT_W(8), .MAGIC(16'hABCD)) dut (
        .clock       (clock),
        .clear_n     (clear_n),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_frame    (in_frame),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_data    (out_data),
        .out_state   (out_state),
        .locked      (locked),
        .fmt_err_cnt (fmt_err_cnt),
        .seq_err_cnt (seq_err_cnt)
    );

    always #5 clock = ~clock;

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    // Any byte the consumer takes must match the oldest forwarded frame.
    always begin
        logic [8:0] exp_item;
        @(negedge clock);
        #2;
        if (clear_n && out_valid && out_ready) begin
            compared++;
            if (sb_q.size() == 0) begin
                mismatched++;
                $display("[TB] FAIL scoreboard_pop: got state=%0b data=%h, no byte expected", out_state, out_data);
            end else begin
                exp_item = sb_q.pop_front();
                if ({out_state, out_data} !== exp_item) begin
                    mismatched++;
                    $display("[TB] FAIL scoreboard_pop: got state=%0b data=%h, want state=%0b data=%h",
                             out_state, out_data, exp_item[8], exp_item[7:0]);
                end
            end
        end
    end

    task automatic model_reset();
        m_locked   = 1'b0;
        m_exp      = 1'b0;
        m_seeded   = 1'b0;
        m_last_fwd = 1'b0;
        m_fmt      = 0;
        m_seq      = 0;
        sb_q.delete();
    endtask

    task automatic model_accept(input logic [31:0] st, input logic [31:0] dt);
        bit wf;
        bit fs;
        wf = (st[31:1] == 31'd0) && (dt[31:24] == ~dt[23:16]) && (dt[15:0] == 16'hABCD);
        fs = st[0];
        m_last_fwd = 1'b0;
        if (!wf) begin
            if (m_fmt < 255) m_fmt++;
        end else if (!STRICT) begin
            m_last_fwd = 1'b1;
            if (!m_locked) begin
                m_exp    = !fs;
                m_locked = 1'b1;
            end else if (fs == m_exp) begin
                m_exp = !m_exp;
            end else begin
                if (m_seq < 255) m_seq++;
                m_locked = 1'b0;
            end
        end else begin
            if (!m_locked) begin
                if (!m_seeded) begin
                    m_seeded = 1'b1;
                    m_exp    = !fs;
                end else if (fs == m_exp) begin
                    m_last_fwd = 1'b1;
                    m_exp      = !m_exp;
                    m_locked   = 1'b1;
                    m_seeded   = 1'b0;
                end else begin
                    m_exp = !fs;
                end
            end else if (fs == m_exp) begin
                m_last_fwd = 1'b1;
                m_exp      = !m_exp;
            end else begin
                if (m_seq < 255) m_seq++;
                m_locked = 1'b0;
                m_seeded = 1'b0;
            end
        end
        if (m_last_fwd) sb_q.push_back({fs, dt[23:16]});
    endtask

    task automatic drive(input bit v, input logic [31:0] st, input logic [31:0] dt,
                         input bit rdy, output bit acc);
        @(negedge clock);
        in_valid  = v;
        in_frame  = {st, dt};
        out_ready = rdy;
        #1;
        acc = v && in_ready;
        if (acc) model_accept(st, dt);
    endtask

    task automatic idle();
        @(negedge clock);
        in_valid = 1'b0;
        #1;
    endtask

    function automatic logic [31:0] good_data(input logic [7:0] b);
        return {~b, b, 16'hABCD};
    endfunction

    task automatic test_reset();
        #3;
        compared++;
        if (out_valid !== 1'b0 || out_data !== 8'h00 || out_state !== 1'b0 || locked !== 1'b0) begin
            mismatched++;
            $display("[TB] FAIL reset_outputs: got v=%b d=%h s=%b l=%b, want 0/00/0/0", out_valid, out_data, out_state, locked);
        end
        compared++;
        if (fmt_err_cnt !== 8'h00 || seq_err_cnt !== 8'h00 || in_ready !== 1'b1) begin
            mismatched++;
            $display("[TB] FAIL reset_counters: got fmt=%h seq=%h rdy=%b, want 00/00/1", fmt_err_cnt, seq_err_cnt, in_ready);
        end
        model_reset();
        @(negedge clock);
        clear_n = 1'b1;
    endtask

    task automatic test_basic();
        bit acc;
        drive(1'b1, 32'd0, 32'hA55AABCD, 1'b1, acc);
        idle();
        compared++;
        if (out_valid !== !STRICT || out_data !== (STRICT ? 8'h00 : 8'h5A) || out_state !== 1'b0) begin
            mismatched++;
            $display("[TB] FAIL basic_first: got v=%b d=%h s=%b, want v=%b d=%h s=0", out_valid, out_data, out_state, !STRICT, STRICT ? 8'h00 : 8'h5A);
        end
        compared++;
        if (locked !== !STRICT) begin
            mismatched++;
            $display("[TB] FAIL basic_locked_first: got %b want %b", locked, !STRICT);
        end
        drive(1'b1, 32'd1, 32'h5AA5ABCD, 1'b1, acc);
        idle();
        compared++;
        if (out_valid !== 1'b1 || out_data !== 8'hA5 || out_state !== 1'b1 || locked !== 1'b1) begin
            mismatched++;
            $display("[TB] FAIL basic_second: got v=%b d=%h s=%b l=%b, want 1/a5/1/1", out_valid, out_data, out_state, locked);
        end
    endtask

    task automatic test_fmt_err();
        bit acc;
        logic [31:0] st_tab [3] = '{32'd0, 32'd0, 32'd2};
        logic [31:0] dt_tab [3] = '{32'hA55A1234, 32'hA45AABCD, 32'hA55AABCD};
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, st_tab[i], dt_tab[i], 1'b1, acc);
            idle();
            compared++;
            if (out_valid !== 1'b0 || fmt_err_cnt !== 8'(i + 1) || fmt_err_cnt !== 8'(m_fmt)) begin
                mismatched++;
                $display("[TB] FAIL fmt_err_%0d: got v=%b fmt=%h, want v=0 fmt=%h", i, out_valid, fmt_err_cnt, 8'(i + 1));
            end
            compared++;
            if (locked !== 1'b1 || seq_err_cnt !== 8'h00) begin
                mismatched++;
                $display("[TB] FAIL fmt_err_lock_%0d: got l=%b seq=%h, want 1/00", i, locked, seq_err_cnt);
            end
        end
    endtask

    task automatic test_seq_err();
        bit acc;
        drive(1'b1, 32'd0, 32'hA55AABCD, 1'b1, acc);
        idle();
        compared++;
        if (out_valid !== 1'b1 || out_data !== 8'h5A || locked !== 1'b1) begin
            mismatched++;
            $display("[TB] FAIL seq_pre: got v=%b d=%h l=%b, want 1/5a/1", out_valid, out_data, locked);
        end
        drive(1'b1, 32'd0, 32'hFF00ABCD, 1'b1, acc);
        idle();
        compared++;
        if (out_valid !== !STRICT || out_data !== (STRICT ? 8'h5A : 8'h00)) begin
            mismatched++;
            $display("[TB] FAIL seq_fwd: got v=%b d=%h, want v=%b d=%h", out_valid, out_data, !STRICT, STRICT ? 8'h5A : 8'h00);
        end
        compared++;
        if (seq_err_cnt !== 8'h01 || locked !== 1'b0) begin
            mismatched++;
            $display("[TB] FAIL seq_count: got seq=%h l=%b, want 01/0", seq_err_cnt, locked);
        end
    endtask

    task automatic test_back_to_back();
        bit acc;
        logic [7:0] b;
        drive(1'b1, 32'd1, 32'h5AA5ABCD, 1'b1, acc);
        drive(1'b1, 32'd0, 32'hA55AABCD, 1'b1, acc);
        idle();
        compared++;
        if (out_valid !== 1'b1 || out_data !== 8'h5A || locked !== 1'b1) begin
            mismatched++;
            $display("[TB] FAIL bp_resync: got v=%b d=%h l=%b, want 1/5a/1", out_valid, out_data, locked);
        end
        drive(1'b1, 32'd1, good_data(8'h3C), 1'b0, acc);
        compared++;
        if (acc !== 1'b1) begin
            mismatched++;
            $display("[TB] FAIL bp_load: got accept=%b want 1", acc);
        end
        for (int i = 0; i < 5; i++) begin
            drive(1'b1, 32'd0, good_data(8'h77), 1'b0, acc);
            compared++;
            if (in_ready !== 1'b0 || out_valid !== 1'b1 || out_data !== 8'h3C || out_state !== 1'b1) begin
                mismatched++;
                $display("[TB] FAIL bp_hold_%0d: got rdy=%b v=%b d=%h s=%b, want 0/1/3c/1", i, in_ready, out_valid, out_data, out_state);
            end
        end
        for (int i = 0; i < 8; i++) begin
            b = (i == 0) ? 8'h77 : 8'($urandom_range(0, 255));
            drive(1'b1, 32'(i % 2), good_data(b), 1'b1, acc);
            compared++;
            if (acc !== 1'b1 || out_valid !== 1'b1) begin
                mismatched++;
                $display("[TB] FAIL b2b_%0d: got accept=%b v=%b, want 1/1", i, acc, out_valid);
            end
        end
        idle();
        compared++;
        if (out_valid !== 1'b1 || seq_err_cnt !== 8'(m_seq) || locked !== m_locked) begin
            mismatched++;
            $display("[TB] FAIL b2b_tail: got v=%b seq=%h l=%b, want 1/%h/%b", out_valid, seq_err_cnt, locked, 8'(m_seq), m_locked);
        end
    endtask

    task automatic test_saturate();
        bit acc;
        for (int i = 0; i < 300; i++) begin
            drive(1'b1, 32'd0, 32'h00001234, 1'b1, acc);
        end
        idle();
        compared++;
        if (fmt_err_cnt !== 8'hFF || out_valid !== 1'b0) begin
            mismatched++;
            $display("[TB] FAIL sat_fmt: got fmt=%h v=%b, want ff/0", fmt_err_cnt, out_valid);
        end
        drive(1'b1, 32'(m_exp), good_data(8'hC3), 1'b1, acc);
        idle();
        compared++;
        if (out_valid !== 1'b1 || out_data !== 8'hC3 || fmt_err_cnt !== 8'hFF) begin
            mismatched++;
            $display("[TB] FAIL sat_forward: got v=%b d=%h fmt=%h, want 1/c3/ff", out_valid, out_data, fmt_err_cnt);
        end
    endtask

    task automatic test_reset_mid();
        bit acc;
        drive(1'b1, 32'(m_exp), good_data(8'h96), 1'b0, acc);
        idle();
        compared++;
        if (out_valid !== 1'b1 || out_data !== 8'h96) begin
            mismatched++;
            $display("[TB] FAIL rst_pre: got v=%b d=%h, want 1/96", out_valid, out_data);
        end
        #3;
        clear_n = 1'b0;
        #1;
        compared++;
        if (out_valid !== 1'b0 || out_data !== 8'h00 || locked !== 1'b0 || fmt_err_cnt !== 8'h00 || seq_err_cnt !== 8'h00) begin
            mismatched++;
            $display("[TB] FAIL rst_mid: got v=%b d=%h l=%b fmt=%h seq=%h, want 0/00/0/00/00",
                     out_valid, out_data, locked, fmt_err_cnt, seq_err_cnt);
        end
        model_reset();
        @(negedge clock);
        clear_n = 1'b1;
        drive(1'b1, 32'd1, good_data(8'h11), 1'b1, acc);
        idle();
        compared++;
        if (locked !== !STRICT || out_valid !== !STRICT) begin
            mismatched++;
            $display("[TB] FAIL rst_resync: got l=%b v=%b, want %b/%b", locked, out_valid, !STRICT, !STRICT);
        end
        idle();
        idle();
        compared++;
        if (sb_q.size() != 0) begin
            mismatched++;
            $display("[TB] FAIL scoreboard_drain: got %0d bytes left, want 0", sb_q.size());
        end
    endtask

    initial begin
        $display("[TB] frame_unpacker bench start (strict=%0b)", STRICT);
        test_reset();
        test_basic();
        test_fmt_err();
        test_seq_err();
        test_back_to_back();
        test_saturate();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
